// File: rtl/generation_sequencer.sv
// Life-grid generation sequencer: sweeps every cell, reads its 3x3 neighbourhood from nine banks, writes results back.
// Optional macro CONWAY_GEN_COUNT_EN builds the completed-generation counter; otherwise gen_count is tied low.
module generation_sequencer #(
  parameter int WIDTH_PIXELS  = 6,
  parameter int HEIGHT_PIXELS = 6,
  parameter int WIDTH_BLOCKS  = 2,
  parameter int HEIGHT_BLOCKS = 2,
  parameter int ADDR_WIDTH    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [8:0]            read_enable,
  output logic [ADDR_WIDTH-1:0] read_addr_0,
  output logic [ADDR_WIDTH-1:0] read_addr_1,
  output logic [ADDR_WIDTH-1:0] read_addr_2,
  output logic [ADDR_WIDTH-1:0] read_addr_3,
  output logic [ADDR_WIDTH-1:0] read_addr_4,
  output logic [ADDR_WIDTH-1:0] read_addr_5,
  output logic [ADDR_WIDTH-1:0] read_addr_6,
  output logic [ADDR_WIDTH-1:0] read_addr_7,
  output logic [ADDR_WIDTH-1:0] read_addr_8,
  output logic [8:0]            write_enable,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic                  frame_buffer_select,
  output logic [15:0]           gen_count
);
  localparam int AW = ADDR_WIDTH;
  localparam logic [AW-1:0] X_LAST = AW'(WIDTH_PIXELS / 3 - 1);
  localparam logic [AW-1:0] Y_LAST = AW'(HEIGHT_PIXELS / 3 - 1);
  localparam logic [AW-1:0] WB     = AW'(WIDTH_BLOCKS);
  localparam logic [AW-1:0] ZERO   = AW'(1'b0);
  localparam logic [AW-1:0] ONE    = AW'(1'b1);

  if (WIDTH_BLOCKS * 3 != WIDTH_PIXELS || HEIGHT_BLOCKS * 3 != HEIGHT_PIXELS ||
      (2 ** ADDR_WIDTH) < WIDTH_BLOCKS * HEIGHT_BLOCKS) begin : g_bad_cfg
    $error("generation_sequencer: inconsistent grid parameters");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, DRAIN = 2'd2, SWAP = 2'd3} state_t;

  state_t        state_r;
  logic [AW-1:0] xb_r, yb_r;
  logic [1:0]    xm_r, ym_r;
  logic [3:0]    cur_bank_r;
  logic [AW-1:0] cur_addr_r;

  logic [AW+1:0] xp_s, xn_s, yp_s, yn_s;
  logic [AW-1:0] col_blk_s [4];
  logic [AW-1:0] row_blk_s [4];
  logic [AW-1:0] nb_addr_s [9];
  logic          x_wrap_s, sweep_end_s, load_s;

  // Coordinates travel as {block, phase}; stepping by one never needs a divider.
  function automatic logic [AW+1:0] coord_dec(input logic [AW-1:0] b, input logic [1:0] m,
                                              input logic [AW-1:0] last);
    logic [AW+1:0] r;
    if (m != 2'd0) r = {b, m - 2'd1};
    else if (b == ZERO) r = {last, 2'd2};
    else r = {b - ONE, 2'd2};
    return r;
  endfunction

  function automatic logic [AW+1:0] coord_inc(input logic [AW-1:0] b, input logic [1:0] m,
                                              input logic [AW-1:0] last);
    logic [AW+1:0] r;
    if (m != 2'd2) r = {b, m + 2'd1};
    else if (b == last) r = {ZERO, 2'd0};
    else r = {b + ONE, 2'd0};
    return r;
  endfunction

  function automatic logic [AW-1:0] bank_addr(input logic [AW-1:0] rb, input logic [AW-1:0] cb);
    return rb * WB + cb;
  endfunction

  // Neighbour block per bank row/column: three consecutive wrapped coordinates cover phases 0..2 once.
  always_comb begin
    xp_s = coord_dec(xb_r, xm_r, X_LAST);
    xn_s = coord_inc(xb_r, xm_r, X_LAST);
    yp_s = coord_dec(yb_r, ym_r, Y_LAST);
    yn_s = coord_inc(yb_r, ym_r, Y_LAST);
    for (int i = 0; i < 4; i++) begin
      col_blk_s[i] = ZERO;
      row_blk_s[i] = ZERO;
    end
    col_blk_s[xm_r]       = xb_r;
    col_blk_s[xp_s[1:0]]  = xp_s[AW+1:2];
    col_blk_s[xn_s[1:0]]  = xn_s[AW+1:2];
    row_blk_s[ym_r]       = yb_r;
    row_blk_s[yp_s[1:0]]  = yp_s[AW+1:2];
    row_blk_s[yn_s[1:0]]  = yn_s[AW+1:2];
    for (int b = 0; b < 9; b++) nb_addr_s[b] = bank_addr(row_blk_s[b / 3], col_blk_s[b % 3]);
    x_wrap_s    = (xm_r == 2'd2) && (xb_r == X_LAST);
    sweep_end_s = (xb_r == ZERO) && (xm_r == 2'd0) && (yb_r == ZERO) && (ym_r == 2'd0);
    load_s      = ((state_r == IDLE) && start) || ((state_r == SWEEP) && !sweep_end_s);
  end

  // Read path and cell counters; counters wrap back to zero after the last cell.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_enable <= 9'h000;
      {read_addr_0, read_addr_1, read_addr_2} <= {3{ZERO}};
      {read_addr_3, read_addr_4, read_addr_5} <= {3{ZERO}};
      {read_addr_6, read_addr_7, read_addr_8} <= {3{ZERO}};
      xb_r <= ZERO;  xm_r <= 2'd0;  yb_r <= ZERO;  ym_r <= 2'd0;
      cur_bank_r <= 4'd0;
      cur_addr_r <= ZERO;
    end else if (load_s) begin
      read_enable <= 9'h1FF;
      read_addr_0 <= nb_addr_s[0];  read_addr_1 <= nb_addr_s[1];  read_addr_2 <= nb_addr_s[2];
      read_addr_3 <= nb_addr_s[3];  read_addr_4 <= nb_addr_s[4];  read_addr_5 <= nb_addr_s[5];
      read_addr_6 <= nb_addr_s[6];  read_addr_7 <= nb_addr_s[7];  read_addr_8 <= nb_addr_s[8];
      cur_bank_r  <= {2'b00, ym_r} * 4'd3 + {2'b00, xm_r};
      cur_addr_r  <= bank_addr(yb_r, xb_r);
      {xb_r, xm_r} <= xn_s;
      if (x_wrap_s) {yb_r, ym_r} <= yn_s;
      else {yb_r, ym_r} <= {yb_r, ym_r};
    end else begin
      read_enable <= 9'h000;
    end
  end

  // Sequencer FSM: write slot trails each read by one cycle; SWAP flips the frame buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r             <= IDLE;
      busy                <= 1'b0;
      done                <= 1'b0;
      write_enable        <= 9'h000;
      write_addr          <= ZERO;
      frame_buffer_select <= 1'b0;
    end else begin
      done         <= 1'b0;
      write_enable <= 9'h000;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= SWEEP;
            busy    <= 1'b1;
          end
        end
        SWEEP: begin
          write_enable <= 9'h001 << cur_bank_r;
          write_addr   <= cur_addr_r;
          if (sweep_end_s) state_r <= DRAIN;
        end
        DRAIN: begin
          state_r             <= SWAP;
          done                <= 1'b1;
          frame_buffer_select <= ~frame_buffer_select;
        end
        SWAP: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef CONWAY_GEN_COUNT_EN
  // Completed-generation count, updated as SWAP is entered so it lines up with done.
  always_ff @(posedge clk) begin
    if (reset) gen_count <= 16'h0000;
    else if (state_r == DRAIN) gen_count <= gen_count + 16'h0001;
    else gen_count <= gen_count;
  end
`else
  assign gen_count = 16'h0000;
`endif

endmodule

// File: tb/tb_generation_sequencer.sv
// Directed bench for generation_sequencer on a 6x6 grid; gen_count expectation follows CONWAY_GEN_COUNT_EN.
module tb_generation_sequencer;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic busy, done, frame_buffer_select;
  logic [8:0] read_enable, write_enable;
  logic [1:0] ra0, ra1, ra2, ra3, ra4, ra5, ra6, ra7, ra8, write_addr;
  logic [15:0] gen_count;
  int vectors = 0, miscompares = 0;
  logic [15:0] gen_exp = 16'h0000;
  logic fbs_exp = 1'b0;

  generation_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .read_enable(read_enable),
    .read_addr_0(ra0), .read_addr_1(ra1), .read_addr_2(ra2), .read_addr_3(ra3), .read_addr_4(ra4),
    .read_addr_5(ra5), .read_addr_6(ra6), .read_addr_7(ra7), .read_addr_8(ra8),
    .write_enable(write_enable), .write_addr(write_addr),
    .frame_buffer_select(frame_buffer_select), .gen_count(gen_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] gc_expect(input logic [15:0] model);
`ifdef CONWAY_GEN_COUNT_EN
    return model;
`else
    return 16'h0000 & model;
`endif
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    gen_exp = 16'h0000; fbs_exp = 1'b0;
    vectors++;
    if ({busy, done, frame_buffer_select} !== 3'b000) begin
      miscompares++; $display("FAIL reset_status got %b exp 000", {busy, done, frame_buffer_select});
    end
    vectors++;
    if ({read_enable, write_enable, write_addr} !== 20'h0) begin
      miscompares++; $display("FAIL reset_strobes got re=%h we=%h wa=%h exp 0", read_enable, write_enable, write_addr);
    end
    vectors++;
    if ((|{ra0, ra1, ra2, ra3, ra4, ra5, ra6, ra7, ra8}) !== 1'b0) begin
      miscompares++; $display("FAIL reset_read_addr got nonzero exp 0");
    end
    vectors++;
    if (gen_count !== 16'h0000) begin
      miscompares++; $display("FAIL reset_gen_count got %h exp 0000", gen_count);
    end
    reset = 1'b0;
  endtask

  // One generation with per-cycle strobe model and the two address spot cells.
  task automatic test_single_gen();
    int we_cnt = 0, busy_cnt = 0, done_k = -1, j;
    logic [8:0] we_exp, re_exp;
    logic [1:0] wa_exp;
    start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (write_enable !== 9'h000) we_cnt++;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_k = k;
      re_exp = (k >= 1 && k <= 36) ? 9'h1FF : 9'h000;
      we_exp = 9'h000; wa_exp = 2'd0;
      if (k >= 2 && k <= 37) begin
        j = k - 2;
        we_exp = 9'h001 << (((j / 6) % 3) * 3 + (j % 6) % 3);
        wa_exp = 2'(((j / 6) / 3) * 2 + (j % 6) / 3);
      end
      vectors++;
      if (read_enable !== re_exp || write_enable !== we_exp || (we_exp != 9'h000 && write_addr !== wa_exp)) begin
        miscompares++;
        $display("FAIL gen_strobe k=%0d got re=%h we=%h wa=%0d exp re=%h we=%h wa=%0d",
                 k, read_enable, write_enable, write_addr, re_exp, we_exp, wa_exp);
      end
      if (k == 1) begin
        vectors++;
        if (ra4 !== 2'd0 || ra8 !== 2'd3) begin
          miscompares++; $display("FAIL cell00_read got ra4=%0d ra8=%0d exp 0 3", ra4, ra8);
        end
      end
      if (k == 23) begin
        vectors++;
        if (ra0 !== 2'd3 || ra5 !== 2'd3 || ra6 !== 2'd1) begin
          miscompares++; $display("FAIL cell43_read got ra0=%0d ra5=%0d ra6=%0d exp 3 3 1", ra0, ra5, ra6);
        end
      end
    end
    gen_exp = gen_exp + 16'h0001; fbs_exp = ~fbs_exp;
    vectors++;
    if (we_cnt != 36) begin miscompares++; $display("FAIL write_count got %0d exp 36", we_cnt); end
    vectors++;
    if (busy_cnt != 38) begin miscompares++; $display("FAIL busy_cycles got %0d exp 38", busy_cnt); end
    vectors++;
    if (done_k != 38) begin miscompares++; $display("FAIL done_cycle got %0d exp 38", done_k); end
    vectors++;
    if (frame_buffer_select !== fbs_exp || gen_count !== gc_expect(gen_exp)) begin
      miscompares++; $display("FAIL gen_end got fbs=%b gc=%h exp fbs=%b gc=%h",
                              frame_buffer_select, gen_count, fbs_exp, gc_expect(gen_exp));
    end
  endtask

  task automatic test_start_while_busy();
    start = 1'b1;
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      start = (k == 5 || k == 20) ? 1'b1 : 1'b0;
      vectors++;
      if (busy !== (k <= 38) || done !== (k == 38)) begin
        miscompares++; $display("FAIL busy_ignore k=%0d got busy=%b done=%b exp busy=%b done=%b",
                                k, busy, done, (k <= 38), (k == 38));
      end
    end
    gen_exp = gen_exp + 16'h0001; fbs_exp = ~fbs_exp;
    vectors++;
    if (frame_buffer_select !== fbs_exp || gen_count !== gc_expect(gen_exp)) begin
      miscompares++; $display("FAIL busy_ignore_end got fbs=%b gc=%h exp fbs=%b gc=%h",
                              frame_buffer_select, gen_count, fbs_exp, gc_expect(gen_exp));
    end
  endtask

  // Start held high: generations follow with exactly one IDLE cycle between them.
  task automatic test_back_to_back();
    logic busy_exp, done_exp;
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    gen_exp = 16'h0000; fbs_exp = 1'b0;
    start = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      done_exp = (k == 38 || k == 77 || k == 116);
      busy_exp = !(k == 39 || k == 78 || k >= 117);
      if (done_exp) begin gen_exp = gen_exp + 16'h0001; fbs_exp = ~fbs_exp; end
      vectors++;
      if (busy !== busy_exp || done !== done_exp) begin
        miscompares++; $display("FAIL b2b_timing k=%0d got busy=%b done=%b exp busy=%b done=%b",
                                k, busy, done, busy_exp, done_exp);
      end
      if (done_exp) begin
        vectors++;
        if (frame_buffer_select !== fbs_exp || gen_count !== gc_expect(gen_exp)) begin
          miscompares++; $display("FAIL b2b_swap k=%0d got fbs=%b gc=%h exp fbs=%b gc=%h",
                                  k, frame_buffer_select, gen_count, fbs_exp, gc_expect(gen_exp));
        end
      end
      if (k == 116) start = 1'b0;
    end
    vectors++;
    if (gen_count !== gc_expect(16'd3)) begin
      miscompares++; $display("FAIL b2b_gen_count got %h exp %h", gen_count, gc_expect(16'd3));
    end
  endtask

  task automatic test_reset_mid_sweep();
    start = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 21) begin
        vectors++;
        if (read_enable !== 9'h1FF || busy !== 1'b1) begin
          miscompares++; $display("FAIL abort_pre got re=%h busy=%b exp 1ff 1", read_enable, busy);
        end
        reset = 1'b1;
      end
      if (k == 22) begin
        reset = 1'b0;
        vectors++;
        if ({busy, done, frame_buffer_select, read_enable, write_enable, write_addr, gen_count} !== 37'h0 ||
            (|{ra0, ra1, ra2, ra3, ra4, ra5, ra6, ra7, ra8}) !== 1'b0) begin
          miscompares++; $display("FAIL abort_reset got busy=%b fbs=%b re=%h we=%h wa=%0d gc=%h exp all 0",
                                  busy, frame_buffer_select, read_enable, write_enable, write_addr, gen_count);
        end
      end
      if (k == 24) begin
        vectors++;
        if (busy !== 1'b0 || write_enable !== 9'h000) begin
          miscompares++; $display("FAIL abort_idle got busy=%b we=%h exp 0 000", busy, write_enable);
        end
      end
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (read_enable !== 9'h1FF || ra4 !== 2'd0 || ra8 !== 2'd3) begin
      miscompares++; $display("FAIL restart_read got re=%h ra4=%0d ra8=%0d exp 1ff 0 3", read_enable, ra4, ra8);
    end
    @(negedge clk);
    vectors++;
    if (write_enable !== 9'h001 || write_addr !== 2'd0) begin
      miscompares++; $display("FAIL restart_write got we=%h wa=%0d exp 001 0", write_enable, write_addr);
    end
  endtask

  initial begin
    test_reset();
    test_single_gen();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
